// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
// The DELAY state exists only when SCCB_DELAY_CMD_EN is defined.
package sccb_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StGap,
`ifdef SCCB_DELAY_CMD_EN
    StDelay,
`endif
    StDone,
    StErr
  } state_t;

  localparam logic [15:0] CfgTerm         = 16'hFFFF;
  localparam logic [15:0] CfgDelay        = 16'hFFF0;
  localparam logic [7:0]  DefaultDeviceId = 8'h42;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table: {reg, value} entries, registered output (1-cycle latency).
module ov7670_cfg_rom
  import sccb_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      case (addr)
        8'd0:    data <= 16'h1280;  // COM7 soft reset
        8'd1:    data <= CfgDelay;  // let the sensor settle after reset
        8'd2:    data <= 16'h1204;  // COM7: RGB output
        default: data <= CfgTerm;
      endcase
    end
  end

endmodule

// File: rtl/sccb_config_seq.sv
// Walks the OV7670 config table and issues one SCCB write request per entry.
// Define SCCB_DELAY_CMD_EN to make entry 16'hFFF0 a DELAY_CYCLES pause.
module sccb_config_seq
  import sccb_cfg_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ID      = DefaultDeviceId,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned DELAY_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] reg_addr,
  output logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] index
);

  localparam int unsigned CntMax = max3(GAP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] GapLast = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] TmoLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`ifdef SCCB_DELAY_CMD_EN
  localparam logic [CntW-1:0] DelayLast = CntW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
`endif

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     rom_data;

  assign id = DEVICE_ID;

  ov7670_cfg_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (index),
    .data  (rom_data)
  );

  // cnt_q is shared: FETCH wait flag, SEND timeout, GAP length and DELAY length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      send     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      index    <= '0;
      reg_addr <= '0;
      value    <= '0;
    end else begin
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            index   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StFetch: begin
          // First FETCH cycle only addresses the ROM; the entry is valid on the second.
          if (cnt_q == '0) begin
            cnt_q <= CntW'(1);
          end else begin
            cnt_q <= '0;
            if (rom_data == CfgTerm) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else if (index == 8'hFF) begin
              state_q <= StErr;
              error   <= 1'b1;
              busy    <= 1'b0;
`ifdef SCCB_DELAY_CMD_EN
            end else if (rom_data == CfgDelay) begin
              state_q <= StDelay;
`endif
            end else begin
              state_q  <= StSend;
              send     <= 1'b1;
              reg_addr <= rom_data[15:8];
              value    <= rom_data[7:0];
            end
          end
        end
        StSend: begin
          if (taken) begin
            state_q <= StGap;
            send    <= 1'b0;
            index   <= index + 8'd1;
            cnt_q   <= '0;
          end else if (cnt_q == TmoLast) begin
            state_q <= StErr;
            send    <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q <= StFetch;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef SCCB_DELAY_CMD_EN
        StDelay: begin
          if (cnt_q == DelayLast) begin
            state_q <= StFetch;
            index   <= index + 8'd1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          send    <= 1'b0;
          busy    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench: table of expected SCCB transactions plus timeout, reset and restart sequences.
module tb_sccb_config_seq;

  localparam int unsigned Gap   = 4;
  localparam int unsigned Delay = 50;

  logic       clk = 1'b0;
  logic       rst_n, start, taken, start_t;
  logic       send, busy, done, error;
  logic [7:0] id, reg_addr, value, index;
  logic       send_t, busy_t, done_t, error_t;
  logic [7:0] id_t, reg_addr_t, value_t, index_t;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned ack_lat;
    logic [7:0]  idx;
    logic [7:0]  ra;
    logic [7:0]  val;
    int unsigned gap_after;
  } txn_t;

  txn_t tbl[3];
  int   n_txn;

  always #5 clk = ~clk;

  sccb_config_seq #(
    .DEVICE_ID      (8'h42),
    .GAP_CYCLES     (Gap),
    .DELAY_CYCLES   (Delay),
    .TIMEOUT_CYCLES (1000)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .taken    (taken),
    .send     (send),
    .id       (id),
    .reg_addr (reg_addr),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .index    (index)
  );

  sccb_config_seq #(
    .DEVICE_ID      (8'h42),
    .GAP_CYCLES     (Gap),
    .DELAY_CYCLES   (Delay),
    .TIMEOUT_CYCLES (100)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_t),
    .taken    (1'b0),
    .send     (send_t),
    .id       (id_t),
    .reg_addr (reg_addr_t),
    .value    (value_t),
    .busy     (busy_t),
    .done     (done_t),
    .error    (error_t),
    .index    (index_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_table(input bit poke);
    int  n;
    bit  stable;
    for (int i = 0; i < n_txn; i++) begin
      n = 0;
      while (!send && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("send_seen", send, 1'b1);
      check("index", index, tbl[i].idx);
      check("reg_addr", reg_addr, tbl[i].ra);
      check("value", value, tbl[i].val);
      check("id", id, 8'h42);
      stable = 1'b1;
      for (int k = 0; k < int'(tbl[i].ack_lat); k++) begin
        if (!(send && reg_addr == tbl[i].ra && value == tbl[i].val)) stable = 1'b0;
        @(negedge clk);
      end
      check("hold_stable", stable, 1'b1);
      taken = 1'b1;
      @(negedge clk);
      check("send_drop", send, 1'b0);
      n = 0;
      while (!(send || done) && n < 200) begin
        if (poke && i == 0 && n == 0) begin
          start = 1'b1;
          taken = 1'b1;
        end else begin
          start = 1'b0;
          taken = 1'b0;
        end
        if (poke && i == 0 && n == 2) begin
          check("busy_ignores_start", busy, 1'b1);
          check("index_ignores_start", index, 8'd1);
        end
        n++;
        @(negedge clk);
      end
      start = 1'b0;
      taken = 1'b0;
      check("gap_len", n, tbl[i].gap_after);
    end
    check("done_end", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("index_end", index, 8'd3);
  endtask

  initial begin
    int n;
`ifdef SCCB_DELAY_CMD_EN
    tbl[0] = '{ack_lat: 20,  idx: 8'd0, ra: 8'h12, val: 8'h80, gap_after: Gap + Delay + 4};
    tbl[1] = '{ack_lat: 500, idx: 8'd2, ra: 8'h12, val: 8'h04, gap_after: Gap + 2};
    n_txn  = 2;
`else
    tbl[0] = '{ack_lat: 20,  idx: 8'd0, ra: 8'h12, val: 8'h80, gap_after: Gap + 2};
    tbl[1] = '{ack_lat: 500, idx: 8'd1, ra: 8'hFF, val: 8'hF0, gap_after: Gap + 2};
    tbl[2] = '{ack_lat: 20,  idx: 8'd2, ra: 8'h12, val: 8'h04, gap_after: Gap + 2};
    n_txn  = 3;
`endif
    rst_n   = 1'b0;
    start   = 1'b0;
    taken   = 1'b0;
    start_t = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send", send, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_index", index, 8'd0);
    check("rst_reg_addr", reg_addr, 8'd0);
    check("rst_value", value, 8'd0);
    check("rst_id", id, 8'h42);
    rst_n = 1'b1;
    @(negedge clk);

    // Timeout: sender never acknowledges.
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    n = 0;
    while (!send_t && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo_send_seen", send_t, 1'b1);
    n = 0;
    while (send_t && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("tmo_send_cycles", n, 100);
    check("tmo_error", error_t, 1'b1);
    check("tmo_send", send_t, 1'b0);
    check("tmo_busy", busy_t, 1'b0);
    check("tmo_done", done_t, 1'b0);

    // Normal run with start/taken pokes during the first gap.
    pulse_start();
    check("start_busy", busy, 1'b1);
    run_table(1'b1);
    taken = 1'b1;
    @(negedge clk);
    taken = 1'b0;
    @(negedge clk);
    check("done_taken_ignored", done, 1'b1);
    check("done_busy_low", busy, 1'b0);

    // Restart from DONE.
    pulse_start();
    check("restart_done_clr", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_index", index, 8'd0);
    run_table(1'b0);

    // Asynchronous reset while in SEND, then rerun.
    pulse_start();
    n = 0;
    while (!send && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("pre_rst_send", send, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_send", send, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_index", index, 8'd0);
    check("arst_reg_addr", reg_addr, 8'd0);
    check("arst_value", value, 8'd0);
    check("arst_tmo_error", error_t, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_send", send, 1'b0);
    pulse_start();
    run_table(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
